prim_slice_packer: RTL

// - Inverse of the slicer primitive. Collects a stream of SliceW-bit beats, LSB-first.
// - Packs them into one WordW-bit word and presents it on a valid/ready output.
// - Handles fractional WordW/SliceW: bits of the final beat above WordW are dropped.
// - A word ended early by slice_last_i is zero-filled in its upper beats.
// - Sits on the receive side of narrow datapaths (e.g. byte-wide key/message loaders) that feed wide registers.

---
 rtl/prim_slice_packer_pkg.sv | 9 +
 rtl/prim_slice_packer.sv | 97 +++++++++
 2 files changed

// File: rtl/prim_slice_packer_pkg.sv
// Helpers shared by the slice packer files.
package prim_slice_packer_pkg;

  // Integer ceiling division, used to size the beat buffer.
  function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/prim_slice_packer.sv
// Slice packer: assembles LSB-first SliceW-bit beats into one WordW-bit word.
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   clear_i                       synchronous abort of partial and pending words
//   slice_valid_i/ready_o/data_i  input beat handshake and payload
//   slice_last_i                  ends the current word early
//   word_valid_o/ready_i/data_o   assembled word handshake and payload
//   word_nbeats_o                 beats contained in word_data_o (1..NumBeats)
module prim_slice_packer
  import prim_slice_packer_pkg::*;
#(
  parameter int unsigned WordW  = 64,
  parameter int unsigned SliceW = 8,
  parameter int unsigned IndexW = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              slice_valid_i,
  output logic              slice_ready_o,
  input  logic [SliceW-1:0] slice_data_i,
  input  logic              slice_last_i,
  output logic              word_valid_o,
  input  logic              word_ready_i,
  output logic [WordW-1:0]  word_data_o,
  output logic [IndexW:0]   word_nbeats_o
);

  localparam int unsigned NumBeats = ceil_div(WordW, SliceW);
  localparam int unsigned CntW     = IndexW + 1;
  localparam int unsigned BufW     = SliceW * NumBeats;
  localparam logic [IndexW-1:0] LastIdx = IndexW'(NumBeats - 1);

  // Beat index must be able to address every beat of the word.
  if (WordW > SliceW * (2 ** IndexW)) begin : g_param_check
    $error("prim_slice_packer: WordW exceeds SliceW*2**IndexW");
  end

  logic [IndexW-1:0] cnt_q;
  logic [BufW-1:0]   unrolled_buf_q;
  logic [BufW-1:0]   buf_d;
  logic              beat_acc;
  logic              word_drain;
  logic              word_done;

  assign slice_ready_o = !clear_i && (!word_valid_o || word_ready_i);
  assign beat_acc      = slice_valid_i && slice_ready_o;
  assign word_drain    = word_valid_o && word_ready_i;
  assign word_done     = beat_acc && ((cnt_q == LastIdx) || slice_last_i);
  assign word_data_o   = unrolled_buf_q[WordW-1:0];

  // Next buffer: beat 0 zero-fills the upper beats, then the beat lands at its slot.
  always_comb begin
    buf_d = (cnt_q == '0) ? '0 : unrolled_buf_q;
    for (int unsigned b = 0; b < NumBeats; b++) begin
      if (cnt_q == IndexW'(b)) begin
        buf_d[b*SliceW +: SliceW] = slice_data_i;
      end
    end
  end

  // FILL/FULL is carried by word_valid_o together with the beat counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q          <= '0;
      unrolled_buf_q <= '0;
      word_valid_o   <= 1'b0;
      word_nbeats_o  <= '0;
    end else if (clear_i) begin
      cnt_q        <= '0;
      word_valid_o <= 1'b0;
    end else begin
      if (beat_acc) begin
        unrolled_buf_q <= buf_d;
      end
      if (word_done) begin
        // A drain in the same cycle is superseded by the new word.
        cnt_q         <= '0;
        word_valid_o  <= 1'b1;
        word_nbeats_o <= CntW'(cnt_q) + CntW'(1);
      end else begin
        if (beat_acc) begin
          cnt_q <= cnt_q + IndexW'(1);
        end
        if (word_drain) begin
          word_valid_o <= 1'b0;
        end
      end
    end
  end

  // slice_last_i is only meaningful alongside a valid beat.
  a_last_needs_valid: assert property (
    @(posedge clk_i) disable iff (!rst_ni) slice_last_i |-> slice_valid_i
  );

endmodule
